// File: rtl/tone_gen_prog.sv
// tone_gen_prog: square-wave tone generator with a runtime-writable half-period
// table, gated start and clean stop at a half-cycle boundary.
// Optional feature macro: TONE_OCTAVE_EN adds the OCTAVE input. When it is
// defined, the latched half-period is max(table >> OCTAVE, 2).
module tone_gen_prog #(
    parameter int                           NUM_NOTES  = 4,
    parameter int                           CNT_W      = 14,
    parameter logic [NUM_NOTES*CNT_W-1:0]   TABLE_INIT = {14'd7584, 14'd9020, 14'd11363, 14'd13514},
    localparam int                          IW         = $clog2(NUM_NOTES)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             GATE,
    input  logic [IW-1:0]    NOTE_SEL,
    input  logic             WR_EN,
    input  logic [IW-1:0]    WR_ADDR,
    input  logic [CNT_W-1:0] WR_DATA,
`ifdef TONE_OCTAVE_EN
    input  logic [1:0]       OCTAVE,
`endif
    output logic             AUDIO,
    output logic             ACTIVE,
    output logic [IW-1:0]    NOTE_CUR,
    output logic             TOGGLE
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_HALF  = CNT_W'(2);
    localparam logic [IW:0]      NOTES_LIM = (IW+1)'(NUM_NOTES);

    logic [CNT_W-1:0] tbl [NUM_NOTES];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             audio_d, toggle_d;
    logic [IW-1:0]    note_d;
    logic             latch;
    logic             terminal;
    logic             run_like;
    logic [CNT_W-1:0] sel_half;
    logic [CNT_W-1:0] latch_half;

    // Half-period table: reset to TABLE_INIT, written by the single-cycle strobe.
    // NOTE: the table is a small register file, so it is reset like any other
    // register; a RAM macro could not be restored to TABLE_INIT this way.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NUM_NOTES; i++) begin
                tbl[i] <= TABLE_INIT[i*CNT_W +: CNT_W];
            end
        end else if (WR_EN && ({1'b0, WR_ADDR} < NOTES_LIM)) begin
            tbl[WR_ADDR] <= (WR_DATA < MIN_HALF) ? MIN_HALF : WR_DATA;
        end
    end

    // Half-period for the requested note; out-of-range selects fall back to entry 0.
    always_comb begin
        sel_half = tbl[0];
        if ({1'b0, NOTE_SEL} < NOTES_LIM) begin
            sel_half = tbl[NOTE_SEL];
        end
`ifdef TONE_OCTAVE_EN
        latch_half = sel_half >> OCTAVE;
        if (latch_half < MIN_HALF) begin
            latch_half = MIN_HALF;
        end
`else
        latch_half = sel_half;
`endif
    end

    assign terminal = (cnt_q == (half_q - CNT_W'(1)));
    // DRAIN with GATE raised again behaves exactly like RUN, so the waveform is undisturbed.
    assign run_like = (state_q == S_RUN) || ((state_q == S_DRAIN) && GATE);

    // Next-state and next-output logic.
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        audio_d  = AUDIO;
        toggle_d = 1'b0;
        latch    = 1'b0;
        half_d   = half_q;
        note_d   = NOTE_CUR;

        unique case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                audio_d = 1'b0;
                if (GATE) begin
                    state_d  = S_RUN;
                    audio_d  = 1'b1;
                    toggle_d = 1'b1;
                    latch    = 1'b1;
                end
            end
            S_RUN, S_DRAIN: begin
                if (run_like) begin
                    state_d = GATE ? S_RUN : S_DRAIN;
                    if (terminal) begin
                        cnt_d    = '0;
                        audio_d  = ~AUDIO;
                        toggle_d = 1'b1;
                        latch    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (terminal) begin
                    // Draining: finish on a low level, emitting a falling edge only if needed.
                    cnt_d    = '0;
                    audio_d  = 1'b0;
                    toggle_d = AUDIO;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                audio_d = 1'b0;
            end
        endcase

        // Sole point where a new note is taken: always at a half-cycle boundary.
        if (latch) begin
            half_d = latch_half;
            note_d = NOTE_SEL;
        end
    end

    // State, counter and output registers; reset forces AUDIO low immediately.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            half_q   <= '0;
            AUDIO    <= 1'b0;
            TOGGLE   <= 1'b0;
            ACTIVE   <= 1'b0;
            NOTE_CUR <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            half_q   <= half_d;
            AUDIO    <= audio_d;
            TOGGLE   <= toggle_d;
            ACTIVE   <= (state_d != S_IDLE);
            NOTE_CUR <= note_d;
        end
    end

endmodule
